work_link_master: RTL and testbench



---
 rtl/work_link_pkg.sv | 25 ++
 rtl/work_link_master_if.sv | 22 ++
 rtl/link_uart.sv | 137 +++++++++++++
 rtl/work_link_master.sv | 191 +++++++++++++++++++
 tb/tb_work_link_master.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/work_link_pkg.sv
// Shared definitions for the serial work link: frame sizes, TX state
// encoding and the bit-period helper.
// Optional build macro: WORK_CHECKSUM_EN adds the TX_CKSUM state.
package work_link_pkg;

  localparam int unsigned WORK_BYTES  = 96;
  localparam int unsigned NONCE_BYTES = 4;
  localparam int unsigned WORK_BITS   = 768;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOAD,
    TX_WAIT_START,
    TX_WAIT_DONE
`ifdef WORK_CHECKSUM_EN
    , TX_CKSUM
`endif
  } tx_state_e;

  // Clocks per UART bit, integer-truncated.
  function automatic int unsigned bit_period(input int unsigned clock, input int unsigned baud);
    return clock / baud;
  endfunction

endpackage

// File: rtl/work_link_master_if.sv
// Work-unit handshake and nonce result bus between the scheduler (master
// modport) and work_link_master (slave modport).
interface work_link_master_if;

  logic         work_valid;
  logic         work_ready;
  logic [511:0] midstate;
  logic [255:0] data2;
  logic [31:0]  nonce;
  logic         nonce_valid;

  modport master (
    output work_valid, midstate, data2,
    input  work_ready, nonce, nonce_valid
  );

  modport slave (
    input  work_valid, midstate, data2,
    output work_ready, nonce, nonce_valid
  );

endinterface

// File: rtl/link_uart.sv
// Byte-level 8N1 UART: transmitter with start/busy handshake and a receiver
// that samples each bit at SAMPLE_POINT/16 of the bit period.
module link_uart #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned SAMPLE_POINT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx_busy,
  output logic       tx,
  input  logic       rx,
  output logic       rx_data_ready,
  output logic [7:0] rx_byte,
  output logic       rx_error
);

  localparam int unsigned CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned SAMPLE_OFS = (CLKS_PER_BIT * SAMPLE_POINT) / 16;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] OFS_LAST = CW'((SAMPLE_OFS == 0) ? 0 : SAMPLE_OFS - 1);

  logic [9:0]    tx_shift_q, tx_shift_d;
  logic [3:0]    tx_bits_q, tx_bits_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic          tx_busy_q, tx_busy_d;

  logic          rx_meta_q, rx_sync_q;
  logic          rx_active_q, rx_active_d;
  logic [3:0]    rx_bits_q, rx_bits_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_ready_q, rx_ready_d;
  logic          rx_err_q, rx_err_d;

  assign tx            = tx_busy_q ? tx_shift_q[0] : 1'b1;
  assign tx_busy       = tx_busy_q;
  assign rx_data_ready = rx_ready_q;
  assign rx_byte       = rx_byte_q;
  assign rx_error      = rx_err_q;

  // Transmit: shift out {stop, data, start} LSB first, one bit per period.
  always_comb begin
    tx_shift_d = tx_shift_q;
    tx_bits_d  = tx_bits_q;
    tx_cnt_d   = tx_cnt_q;
    tx_busy_d  = tx_busy_q;
    if (!tx_busy_q) begin
      if (tx_start) begin
        tx_shift_d = {1'b1, tx_byte, 1'b0};
        tx_bits_d  = '0;
        tx_cnt_d   = '0;
        tx_busy_d  = 1'b1;
      end
    end else if (tx_cnt_q == BIT_LAST) begin
      tx_cnt_d   = '0;
      tx_shift_d = {1'b1, tx_shift_q[9:1]};
      if (tx_bits_q == 4'd9) tx_busy_d = 1'b0;
      else                   tx_bits_d = tx_bits_q + 4'd1;
    end else begin
      tx_cnt_d = tx_cnt_q + CW'(1);
    end
  end

  // Receive: bits_q 0 = start bit, 1..8 = data, 9 = stop bit.
  always_comb begin
    rx_active_d = rx_active_q;
    rx_bits_d   = rx_bits_q;
    rx_cnt_d    = rx_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_byte_d   = rx_byte_q;
    rx_ready_d  = 1'b0;
    rx_err_d    = 1'b0;
    if (!rx_active_q) begin
      if (!rx_sync_q) begin
        rx_active_d = 1'b1;
        rx_bits_d   = '0;
        rx_cnt_d    = '0;
      end
    end else if (rx_cnt_q == ((rx_bits_q == 4'd0) ? OFS_LAST : BIT_LAST)) begin
      rx_cnt_d = '0;
      if (rx_bits_q == 4'd0) begin
        if (rx_sync_q) rx_active_d = 1'b0;   // start-bit glitch
        else           rx_bits_d   = 4'd1;
      end else if (rx_bits_q == 4'd9) begin
        rx_active_d = 1'b0;
        if (rx_sync_q) begin
          rx_ready_d = 1'b1;
          rx_byte_d  = rx_shift_q;
        end else begin
          rx_err_d = 1'b1;
        end
      end else begin
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        rx_bits_d  = rx_bits_q + 4'd1;
      end
    end else begin
      rx_cnt_d = rx_cnt_q + CW'(1);
    end
  end

  // State registers and the two-flop rx synchroniser.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_shift_q  <= '1;
      tx_bits_q   <= '0;
      tx_cnt_q    <= '0;
      tx_busy_q   <= 1'b0;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_active_q <= 1'b0;
      rx_bits_q   <= '0;
      rx_cnt_q    <= '0;
      rx_shift_q  <= '0;
      rx_byte_q   <= '0;
      rx_ready_q  <= 1'b0;
      rx_err_q    <= 1'b0;
    end else begin
      tx_shift_q  <= tx_shift_d;
      tx_bits_q   <= tx_bits_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_busy_q   <= tx_busy_d;
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      rx_active_q <= rx_active_d;
      rx_bits_q   <= rx_bits_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_ready_q  <= rx_ready_d;
      rx_err_q    <= rx_err_d;
    end
  end

endmodule

// File: rtl/work_link_master.sv
// Host end of the mining link: serialises a 768-bit work unit MSB byte
// first over UART and assembles 4-byte nonces from the return path.
// Optional build macro: WORK_CHECKSUM_EN appends an XOR checksum byte.
module work_link_master
  import work_link_pkg::*;
#(
  parameter int unsigned CLOCK         = 25000000,
  parameter int unsigned BAUD          = 57600,
  parameter int unsigned SAMPLE_POINT  = 8,
  parameter int unsigned NONCE_TIMEOUT = 2500000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  output logic               tx,
  work_link_master_if.slave  bus,
  output logic               tx_busy,
  output logic               rx_busy
);

  localparam int unsigned CLKS_PER_BIT = bit_period(CLOCK, BAUD);
  localparam int unsigned TW = (NONCE_TIMEOUT > 1) ? $clog2(NONCE_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(NONCE_TIMEOUT - 1);

  tx_state_e            state_q, state_d;
  logic [WORK_BITS-1:0] sreg_q, sreg_d;
  logic [6:0]           count_q, count_d;
  logic                 work_ready_q, work_ready_d;
`ifdef WORK_CHECKSUM_EN
  logic [7:0]           cksum_q, cksum_d;
  logic                 cksum_sent_q, cksum_sent_d;
`endif

  logic          uart_tx_start;
  logic [7:0]    uart_tx_byte;
  logic          uart_busy;
  logic          uart_rx_ready;
  logic [7:0]    uart_rx_byte;
  logic          uart_rx_error;

  logic [23:0]   shift_q, shift_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [31:0]   nonce_q, nonce_d;
  logic          nonce_valid_q, nonce_valid_d;

  link_uart #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SAMPLE_POINT (SAMPLE_POINT)
  ) u_uart (
    .clk           (clk),
    .reset         (reset),
    .tx_start      (uart_tx_start),
    .tx_byte       (uart_tx_byte),
    .tx_busy       (uart_busy),
    .tx            (tx),
    .rx            (rx),
    .rx_data_ready (uart_rx_ready),
    .rx_byte       (uart_rx_byte),
    .rx_error      (uart_rx_error)
  );

  assign bus.work_ready  = work_ready_q;
  assign bus.nonce       = nonce_q;
  assign bus.nonce_valid = nonce_valid_q;
  assign tx_busy         = (state_q != TX_IDLE);
  assign rx_busy         = (cnt_q != 2'd0);

  // TX framing FSM: next state, shift register and UART start strobe.
  always_comb begin
    state_d       = state_q;
    sreg_d        = sreg_q;
    count_d       = count_q;
    uart_tx_start = 1'b0;
    uart_tx_byte  = sreg_q[WORK_BITS-1 -: 8];
`ifdef WORK_CHECKSUM_EN
    cksum_d       = cksum_q;
    cksum_sent_d  = cksum_sent_q;
`endif
    unique case (state_q)
      TX_IDLE: begin
        if (bus.work_valid && work_ready_q) begin
          sreg_d  = {bus.midstate, bus.data2};
          count_d = 7'(WORK_BYTES - 1);
          state_d = TX_LOAD;
`ifdef WORK_CHECKSUM_EN
          cksum_d      = '0;
          cksum_sent_d = 1'b0;
`endif
        end
      end
      TX_LOAD: begin
        uart_tx_start = 1'b1;
        sreg_d        = {sreg_q[WORK_BITS-9:0], 8'h00};
        state_d       = TX_WAIT_START;
`ifdef WORK_CHECKSUM_EN
        cksum_d       = cksum_q ^ sreg_q[WORK_BITS-1 -: 8];
`endif
      end
      TX_WAIT_START: begin
        if (uart_busy) state_d = TX_WAIT_DONE;
      end
      TX_WAIT_DONE: begin
        if (!uart_busy) begin
          if (count_q != '0) begin
            count_d = count_q - 7'd1;
            state_d = TX_LOAD;
          end else begin
`ifdef WORK_CHECKSUM_EN
            state_d = cksum_sent_q ? TX_IDLE : TX_CKSUM;
`else
            state_d = TX_IDLE;
`endif
          end
        end
      end
`ifdef WORK_CHECKSUM_EN
      TX_CKSUM: begin
        uart_tx_start = 1'b1;
        uart_tx_byte  = cksum_q;
        cksum_sent_d  = 1'b1;
        state_d       = TX_WAIT_START;
      end
`endif
      default: state_d = TX_IDLE;
    endcase
    // Registered from the next state so ready drops the cycle after accept.
    work_ready_d = (state_d == TX_IDLE);
  end

  // Nonce assembly with partial-word timeout; a byte in the expiry cycle wins.
  always_comb begin
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    idle_d        = idle_q;
    nonce_d       = nonce_q;
    nonce_valid_d = 1'b0;
    if (uart_rx_ready && !uart_rx_error) begin
      idle_d = '0;
      if (cnt_q == 2'(NONCE_BYTES - 1)) begin
        nonce_d       = {shift_q, uart_rx_byte};
        nonce_valid_d = 1'b1;
        cnt_d         = '0;
      end else begin
        shift_d = {shift_q[15:0], uart_rx_byte};
        cnt_d   = cnt_q + 2'd1;
      end
    end else if (cnt_q != 2'd0) begin
      if (idle_q == TO_LAST) begin
        cnt_d  = '0;
        idle_d = '0;
      end else begin
        idle_d = idle_q + TW'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= TX_IDLE;
      sreg_q        <= '0;
      count_q       <= '0;
      work_ready_q  <= 1'b0;
`ifdef WORK_CHECKSUM_EN
      cksum_q       <= '0;
      cksum_sent_q  <= 1'b0;
`endif
      shift_q       <= '0;
      cnt_q         <= '0;
      idle_q        <= '0;
      nonce_q       <= '0;
      nonce_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sreg_q        <= sreg_d;
      count_q       <= count_d;
      work_ready_q  <= work_ready_d;
`ifdef WORK_CHECKSUM_EN
      cksum_q       <= cksum_d;
      cksum_sent_q  <= cksum_sent_d;
`endif
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      idle_q        <= idle_d;
      nonce_q       <= nonce_d;
      nonce_valid_q <= nonce_valid_d;
    end
  end

endmodule

// File: tb/tb_work_link_master.sv
// Self-checking bench for work_link_master: decodes the tx line, drives
// nonce bytes on rx and compares against a byte/word-level reference model.
module tb_work_link_master;

  localparam int unsigned CLOCK = 25000000;
  localparam int unsigned BAUD  = 3125000;   // 8 clocks per bit
  localparam int unsigned BIT   = 8;
  localparam int unsigned TO    = 400;
`ifdef WORK_CHECKSUM_EN
  localparam int unsigned FRAME = 97;
`else
  localparam int unsigned FRAME = 96;
`endif

  logic clk = 1'b0;
  logic reset;
  logic rx;
  logic tx;
  logic tx_busy;
  logic rx_busy;

  work_link_master_if bus();

  work_link_master #(
    .CLOCK         (CLOCK),
    .BAUD          (BAUD),
    .SAMPLE_POINT  (8),
    .NONCE_TIMEOUT (TO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .tx      (tx),
    .bus     (bus),
    .tx_busy (tx_busy),
    .rx_busy (rx_busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  bit [7:0]    got_q[$];
  bit [7:0]    exp_q[$];
  int unsigned last_start_cyc = 0;
  int unsigned tx_frame_err = 0;
  logic [31:0] nonce_got_q[$];
  logic [31:0] nonce_exp_q[$];
  int unsigned wide_pulses = 0;
  bit [7:0]    unit_b[96];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decode the tx line as 8N1 at mid-bit.
  initial begin
    bit [7:0] b;
    forever begin
      tick();
      if (tx === 1'b0) begin
        last_start_cyc = cyc;
        repeat (BIT / 2) tick();
        if (tx !== 1'b0) tx_frame_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) tick();
          b[i] = tx;
        end
        repeat (BIT) tick();
        if (tx !== 1'b1) tx_frame_err++;
        got_q.push_back(b);
      end
    end
  end

  // Record nonce pulses; a pulse longer than one cycle is counted.
  initial begin
    logic prev = 1'b0;
    forever begin
      tick();
      if (bus.nonce_valid === 1'b1) begin
        if (prev) wide_pulses++;
        else      nonce_got_q.push_back(bus.nonce);
      end
      prev = bus.nonce_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present unit_b on the bus and append its expected byte stream.
  task automatic present_unit();
    bit [7:0] x = 8'h00;
    for (int i = 0; i < 96; i++) begin
      if (i < 64) bus.midstate[511 - 8*i -: 8] = unit_b[i];
      else        bus.data2[255 - 8*(i-64) -: 8] = unit_b[i];
      exp_q.push_back(unit_b[i]);
      x ^= unit_b[i];
    end
`ifdef WORK_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic random_unit();
    for (int i = 0; i < 96; i++) unit_b[i] = 8'($urandom);
  endtask

  task automatic compare_tx(input string tag);
    int unsigned n;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < int'(n); i++)
      check($sformatf("%s_byte[%0d]", tag, i), got_q[i], exp_q[i]);
    check({tag, "_framing"}, tx_frame_err, 0);
    got_q.delete();
    exp_q.delete();
  endtask

  // Wait for work_ready with tx_busy required high until then.
  task automatic wait_ready(input string tag);
    int unsigned n = 0;
    int unsigned drops = 0;
    int unsigned delta;
    while (bus.work_ready !== 1'b1 && n < 2 * FRAME * 10 * BIT + 500) begin
      tick();
      n++;
      if (bus.work_ready !== 1'b1 && tx_busy !== 1'b1) drops++;
    end
    check({tag, "_ready"}, bus.work_ready, 1);
    check({tag, "_busy_held"}, drops, 0);
    delta = cyc - last_start_cyc;
    check({tag, "_ready_after_stop"}, (delta >= 10*BIT && delta <= 10*BIT + 2), 1);
  endtask

  task automatic send_byte(input bit [7:0] b, input bit good);
    rx = 1'b0;
    repeat (BIT) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) tick();
    end
    rx = good;
    repeat (BIT) tick();
    rx = 1'b1;
    if (!good) repeat (2 * BIT) tick();
    repeat (2) tick();
  endtask

  task automatic compare_nonces(input string tag);
    int unsigned n;
    check({tag, "_count"}, nonce_got_q.size(), nonce_exp_q.size());
    n = (nonce_got_q.size() < nonce_exp_q.size()) ? nonce_got_q.size() : nonce_exp_q.size();
    for (int i = 0; i < int'(n); i++)
      check($sformatf("%s_nonce[%0d]", tag, i), nonce_got_q[i], nonce_exp_q[i]);
    check({tag, "_pulse_width"}, wide_pulses, 0);
    nonce_got_q.delete();
    nonce_exp_q.delete();
  endtask

  initial begin
    int unsigned k;
    int unsigned n;
    bit [7:0]    pend[$];
    bit [7:0]    b;

    reset = 1'b1;
    rx = 1'b1;
    bus.work_valid = 1'b0;
    bus.midstate = '0;
    bus.data2 = '0;

    // Reset values
    tick();
    check("rst_tx", tx, 1);
    check("rst_work_ready", bus.work_ready, 0);
    check("rst_nonce", bus.nonce, 0);
    check("rst_nonce_valid", bus.nonce_valid, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_busy", rx_busy, 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("post_rst_ready", bus.work_ready, 1);

    // Work send with the counting pattern 0x00..0x5F
    for (int i = 0; i < 96; i++) unit_b[i] = 8'(i);
    present_unit();
    bus.work_valid = 1'b1;
    tick();
    bus.work_valid = 1'b0;
    check("accept_tx_busy", tx_busy, 1);
    check("accept_ready_low", bus.work_ready, 0);
    n = 0;
    while (tx !== 1'b0 && n < 3) begin
      tick();
      n++;
    end
    check("first_start_bit", tx, 0);
    wait_ready("send");
    compare_tx("send");

    // Backpressure: unit B offered while unit A is sending
    random_unit();
    present_unit();
    bus.work_valid = 1'b1;
    tick();
    random_unit();
    present_unit();
    n = 0;
    while (bus.work_ready !== 1'b1 && n < FRAME * 10 * BIT + 500) begin
      tick();
      n++;
    end
    check("bp_ready_seen", bus.work_ready, 1);
    check("bp_first_done", got_q.size(), FRAME);
    tick();
    bus.work_valid = 1'b0;
    check("bp_second_busy", tx_busy, 1);
    wait_ready("bp");
    compare_tx("bp");

    // Reset during byte 40, then a fresh unit restarts at byte 0
    random_unit();
    present_unit();
    bus.work_valid = 1'b1;
    tick();
    bus.work_valid = 1'b0;
    n = 0;
    while (got_q.size() < 40 && n < 60 * 10 * BIT) begin
      tick();
      n++;
    end
    check("mid_reached_40", (got_q.size() >= 40), 1);
    repeat (3 * BIT) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_tx", tx, 1);
    check("mid_rst_tx_busy", tx_busy, 0);
    check("mid_rst_ready", bus.work_ready, 0);
    reset = 1'b0;
    tick();
    check("mid_rst_ready_after", bus.work_ready, 1);
    repeat (100) tick();
    got_q.delete();
    exp_q.delete();
    tx_frame_err = 0;
    for (int i = 0; i < 96; i++) unit_b[i] = 8'(i);
    present_unit();
    bus.work_valid = 1'b1;
    tick();
    bus.work_valid = 1'b0;
    wait_ready("restart");
    compare_tx("restart");

    // Nonce receive DE AD BE EF
    check("rx_busy_idle", rx_busy, 0);
    send_byte(8'hDE, 1'b1);
    check("rx_busy_b1", rx_busy, 1);
    send_byte(8'hAD, 1'b1);
    check("rx_busy_b2", rx_busy, 1);
    send_byte(8'hBE, 1'b1);
    check("rx_busy_b3", rx_busy, 1);
    send_byte(8'hEF, 1'b1);
    check("rx_busy_b4", rx_busy, 0);
    check("nonce_value", bus.nonce, 32'hDEADBEEF);
    nonce_exp_q.push_back(32'hDEADBEEF);
    compare_nonces("fixed");

    // Timeout discards AA BB
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    check("to_busy_partial", rx_busy, 1);
    repeat (TO - 20) tick();
    check("to_busy_before", rx_busy, 1);
    repeat (30) tick();
    check("to_busy_expired", rx_busy, 0);
    check("to_nonce_kept", bus.nonce, 32'hDEADBEEF);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    nonce_exp_q.push_back(32'h11223344);
    compare_nonces("timeout");

    // Randomised nonce traffic: stale partials, framing errors, short gaps
    for (int r = 0; r < 8; r++) begin
      k = $urandom_range(0, 3);
      for (int j = 0; j < int'(k); j++) begin
        b = 8'($urandom);
        send_byte(b, 1'b1);
        pend.push_back(b);
      end
      if (k != 0) begin
        repeat (TO + 50) tick();
        pend.delete();
        check($sformatf("rand%0d_expired", r), rx_busy, 0);
      end
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), 1'b0);
        b = 8'($urandom);
        send_byte(b, 1'b1);
        pend.push_back(b);
        if (pend.size() == 4) begin
          nonce_exp_q.push_back({pend[0], pend[1], pend[2], pend[3]});
          pend.delete();
        end
        repeat ($urandom_range(0, 40)) tick();
      end
    end
    repeat (10) tick();
    compare_nonces("rand");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
